regfile_sb: RTL and testbench

Parametrised register file for the MIPS datapath: successor to the fixed 32×32 file, with configurable width/depth, a hard-wired zero register, write-to-read bypass, a per-register pending-write scoreboard, and a sequenced bulk-clear engine. Sits between decode (read ports, reservation) and write-back (write port); pipeline control uses the pending flags to detect read-after-write hazards.

---
 rtl/regfile_sb.sv | 114 +++++++++++
 tb/tb_regfile_sb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with bypass,
// pending-write scoreboard and sequenced bulk clear.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              pend_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pend_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic [0:0]                   state_q, state_d;
    logic [ADDR_W-1:0]            idx_q, idx_d;
    logic                         busy;
    logic                         wr_ok;
    logic                         rsv_ok;

    assign busy     = (state_q == S_CLEAR);
    assign clr_busy = busy;

    // Writes and reservations are dropped, not queued, while clearing.
    assign wr_ok  = wr_en && !busy &&
                    !(ZERO_REG && (wr_addr == '0));
    assign rsv_ok = rsv_en && !busy &&
                    !(ZERO_REG && (rsv_addr == '0));

    // Read port A: zero register, then same-cycle bypass, then array.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end else if (wr_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same priority as port A, independent bypass.
    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end else if (wr_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

    // Pending flags come straight from the registered vector.
    assign pend_a = pend_q[rd_addr_a];
    assign pend_b = pend_q[rd_addr_b];

    // Next-state: clear sweep, or write-back then reserve (reserve wins).
    always_comb begin
        mem_d   = mem_q;
        pend_d  = pend_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (busy) begin
            mem_d[idx_q]  = '0;
            pend_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        end else begin
            if (clr_req) begin
                state_d = S_CLEAR;
                idx_d   = '0;
            end
            if (wr_ok) begin
                mem_d[wr_addr]  = wr_data;
                pend_d[wr_addr] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    // State registers; reset also aborts any clear in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '0;
            pend_q  <= '0;
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random + directed stimulus against a
// behavioural model of the register file.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        pend_a, pend_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        clr_req;
    logic        clr_busy;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .pend_a    (pend_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .pend_b    (pend_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain arrays, clear tracked as cycles remaining.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_left;

    function automatic bit m_wacc();
        return wr_en && (m_left == 0) && (wr_addr != 5'd0);
    endfunction

    function automatic bit m_racc();
        return rsv_en && (m_left == 0) && (rsv_addr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_wacc() && (wr_addr == a)) return wr_data;
        return m_mem[a];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  <= 32'd0;
                m_pend[i] <= 1'b0;
            end
            m_left <= 0;
        end else if (m_left > 0) begin
            m_mem[32 - m_left]  <= 32'd0;
            m_pend[32 - m_left] <= 1'b0;
            m_left              <= m_left - 1;
        end else begin
            if (clr_req) m_left <= 32;
            if (m_wacc()) begin
                m_mem[wr_addr]  <= wr_data;
                m_pend[wr_addr] <= 1'b0;
            end
            if (m_racc()) m_pend[rsv_addr] <= 1'b1;
        end
    end

    // Hand-computed expectations posted by the stimulus for this cycle.
    bit          lit_en  [6];
    logic [31:0] lit_exp [6];
    int          busy_len;

    task automatic expect_lit(input int s, input logic [31:0] v);
        lit_en[s]  = 1'b1;
        lit_exp[s] = v;
    endtask

    function automatic logic [31:0] lit_act(input int s);
        case (s)
            0: return rd_data_a;
            1: return rd_data_b;
            2: return {31'd0, pend_a};
            3: return {31'd0, pend_b};
            4: return {31'd0, clr_busy};
            default: return busy_len;
        endcase
    endfunction

    function automatic string lit_nm(input int s);
        case (s)
            0: return "lit_rd_a";
            1: return "lit_rd_b";
            2: return "lit_pend_a";
            3: return "lit_pend_b";
            4: return "lit_busy";
            default: return "lit_busy_len";
        endcase
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h",
                     nm, $time, act, exp);
        end
    endtask

    // Single compare process: model every cycle, plus posted literals.
    always @(negedge clk) begin
        chk("rd_a", rd_data_a, exp_rd(rd_addr_a));
        chk("rd_b", rd_data_b, exp_rd(rd_addr_b));
        chk("pend_a", {31'd0, pend_a}, {31'd0, m_pend[rd_addr_a]});
        chk("pend_b", {31'd0, pend_b}, {31'd0, m_pend[rd_addr_b]});
        chk("busy", {31'd0, clr_busy}, {31'd0, m_left > 0});
        for (int s = 0; s < 6; s++) begin
            if (lit_en[s]) chk(lit_nm(s), lit_act(s), lit_exp[s]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < 6; s++) lit_en[s] = 1'b0;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic scan_zero();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            expect_lit(0, 32'd0);
            expect_lit(1, 32'd0);
            expect_lit(2, 32'd0);
            expect_lit(3, 32'd0);
            expect_lit(4, 32'd0);
            probe();
            tick();
        end
    endtask

    initial begin
        for (int s = 0; s < 6; s++) lit_en[s] = 1'b0;
        busy_len  = 0;
        reset_n   = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rsv_addr  = '0;
        idle_inputs();
        #1 reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        scan_zero();

        // Write with same-cycle bypass, then from the array.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF;
        rd_addr_a = 5'd8;
        expect_lit(0, 32'hDEADBEEF);
        probe(); tick();
        wr_en = 1'b0;
        expect_lit(0, 32'hDEADBEEF);
        probe(); tick();

        // Zero register ignores writes and reservations.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        expect_lit(0, 32'd0);
        expect_lit(1, 32'd0);
        probe(); tick();
        idle_inputs();
        expect_lit(0, 32'd0);
        expect_lit(1, 32'd0);
        expect_lit(2, 32'd0);
        probe(); tick();

        // Scoreboard: reserve, write+reserve, write alone.
        rsv_en = 1'b1; rsv_addr = 5'd9;
        probe(); tick();
        rsv_en = 1'b0; rd_addr_a = 5'd9;
        expect_lit(2, 32'd1);
        probe(); tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        probe(); tick();
        idle_inputs();
        expect_lit(2, 32'd1);
        probe(); tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
        probe(); tick();
        wr_en = 1'b0;
        expect_lit(2, 32'd0);
        expect_lit(0, 32'h9A);
        probe(); tick();

        // Clear: fill, reserve 3 and 20, then sweep.
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        rd_addr_a = 5'd17;
        expect_lit(0, 32'd18);
        rsv_en = 1'b1; rsv_addr = 5'd3;
        probe(); tick();
        rsv_addr = 5'd20;
        probe(); tick();
        rsv_en = 1'b0;
        rd_addr_a = 5'd3; rd_addr_b = 5'd20;
        expect_lit(2, 32'd1);
        expect_lit(3, 32'd1);
        clr_req = 1'b1;
        probe(); tick();
        clr_req = 1'b0;
        busy_len = 0;
        while (clr_busy && busy_len < 100) begin
            busy_len++;
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
            rd_addr_a = 5'd5;
            tick();
        end
        wr_en = 1'b0;
        expect_lit(5, 32'd32);
        probe(); tick();
        scan_zero();

        // Reset in the middle of a clear sweep.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        clr_req = 1'b1;
        probe(); tick();
        clr_req = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        expect_lit(4, 32'd0);
        probe(); tick();
        reset_n = 1'b1;
        rd_addr_a = 5'd7; rd_addr_b = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        expect_lit(0, 32'd0);
        expect_lit(1, 32'h44);
        probe(); tick();
        wr_en = 1'b0;
        expect_lit(1, 32'h44);
        probe(); tick();

        // Randomised traffic, with occasional clears.
        for (int c = 0; c < 1500; c++) begin
            wr_en    = 1'($urandom());
            wr_addr  = 5'($urandom());
            wr_data  = $urandom();
            rsv_en   = 1'($urandom());
            rsv_addr = ($urandom() % 3 == 0) ? wr_addr : 5'($urandom());
            clr_req  = ($urandom() % 150 == 0);
            rd_addr_a = ($urandom() % 3 == 0) ? wr_addr : 5'($urandom());
            rd_addr_b = ($urandom() % 3 == 0) ? rd_addr_a : 5'($urandom());
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
